// File: rtl/rob_multiport.sv
// rob_multiport: circular reorder buffer with multi-port writeback, operand bypass,
// in-order single commit and branch/jalr redirect.
`default_nettype none

module rob_multiport #(
  parameter int BITS     = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [31:0]              issue_pc,
  input  logic [1:0]               issue_type,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic                     issue_ready,
  output logic [BITS-1:0]          issue_id,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*BITS-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]   wb_value,
  input  logic [WB_PORTS-1:0]      wb_taken,
  input  logic [BITS-1:0]          qry_id_1,
  input  logic [BITS-1:0]          qry_id_2,
  output logic                     qry_ready_1,
  output logic                     qry_ready_2,
  output logic [31:0]              qry_value_1,
  output logic [31:0]              qry_value_2,
  output logic                     commit_valid,
  output logic [BITS-1:0]          commit_id,
  output logic [1:0]               commit_type,
  output logic [4:0]               commit_rd,
  output logic [31:0]              commit_value,
  output logic                     flush_out,
  output logic [31:0]              flush_pc,
  output logic [BITS:0]            count,
  output logic                     full,
  output logic                     empty
);

  localparam int         DEPTH       = 2**BITS;
  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;
  localparam logic [1:0] TYPE_JALR   = 2'd3;
  localparam logic [BITS:0] FULL_COUNT = {1'b1, {BITS{1'b0}}};

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] pred_q;
  logic [DEPTH-1:0] taken_q;
  logic [1:0]       type_q  [DEPTH];
  logic [4:0]       rd_q    [DEPTH];
  logic [31:0]      pc4_q   [DEPTH];
  logic [31:0]      alt_q   [DEPTH];
  logic [31:0]      value_q [DEPTH];
  logic [BITS-1:0]  head_q;
  logic [BITS-1:0]  tail_q;
  logic [BITS:0]    count_q;

  logic                commit_fire;
  logic                issue_fire;
  logic                mispredict;
  logic [1:0]          head_type;
  logic [WB_PORTS-1:0] wb_ok;

  assign count       = count_q;
  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign issue_id    = tail_q;
  assign head_type   = type_q[head_q];

  // Commit only sees a registered done bit, so the earliest commit is the cycle after writeback.
  assign commit_fire = rdy_in && !empty && valid_q[head_q] && done_q[head_q];
  assign mispredict  = (head_type == TYPE_BRANCH) && (taken_q[head_q] != pred_q[head_q]);
  assign flush_out   = commit_fire && ((head_type == TYPE_JALR) || mispredict);
  assign flush_pc    = !flush_out ? 32'd0 :
                       (head_type == TYPE_JALR) ? value_q[head_q] : alt_q[head_q];
  assign issue_ready = !full && !flush_out;
  assign issue_fire  = rdy_in && issue_valid && issue_ready;

  assign commit_valid = commit_fire;
  assign commit_id    = commit_fire ? head_q : '0;
  assign commit_type  = commit_fire ? head_type : 2'd0;

  always_comb begin
    commit_rd    = 5'd0;
    commit_value = 32'd0;
    if (commit_fire) begin
      case (head_type)
        TYPE_REG:   begin commit_rd = rd_q[head_q]; commit_value = value_q[head_q]; end
        TYPE_STORE: commit_value = value_q[head_q];
        TYPE_JALR:  begin commit_rd = rd_q[head_q]; commit_value = pc4_q[head_q]; end
        default:    commit_value = 32'd0;
      endcase
    end
  end

  always_comb begin
    wb_ok = '0;
    for (int k = 0; k < WB_PORTS; k++) begin
      wb_ok[k] = rdy_in && !flush_out && wb_valid[k] &&
                 valid_q[wb_id[k*BITS +: BITS]] && !done_q[wb_id[k*BITS +: BITS]];
    end
  end

  // Later ports override earlier ones, so the highest matching port supplies the bypass.
  always_comb begin
    qry_ready_1 = done_q[qry_id_1];
    qry_value_1 = value_q[qry_id_1];
    qry_ready_2 = done_q[qry_id_2];
    qry_value_2 = value_q[qry_id_2];
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && (wb_id[k*BITS +: BITS] == qry_id_1)) begin
        qry_ready_1 = 1'b1;
        qry_value_1 = wb_value[k*32 +: 32];
      end
      if (wb_valid[k] && (wb_id[k*BITS +: BITS] == qry_id_2)) begin
        qry_ready_2 = 1'b1;
        qry_value_2 = wb_value[k*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (rdy_in) begin
      if (flush_out) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        valid_q <= '0;
        done_q  <= '0;
      end else begin
        for (int k = 0; k < WB_PORTS; k++) begin
          if (wb_ok[k]) done_q[wb_id[k*BITS +: BITS]] <= 1'b1;
        end
        if (commit_fire) begin
          valid_q[head_q] <= 1'b0;
          done_q[head_q]  <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        if (issue_fire) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
          tail_q          <= tail_q + 1'b1;
        end
        case ({issue_fire, commit_fire})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (issue_fire) begin
      type_q[tail_q] <= issue_type;
      rd_q[tail_q]   <= issue_rd;
      pc4_q[tail_q]  <= issue_pc + 32'd4;
      alt_q[tail_q]  <= issue_alt_pc;
      pred_q[tail_q] <= issue_pred_taken;
    end
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_ok[k]) begin
        value_q[wb_id[k*BITS +: BITS]] <= wb_value[k*32 +: 32];
        taken_q[wb_id[k*BITS +: BITS]] <= wb_taken[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_multiport.sv
// tb_rob_multiport: directed scenarios plus randomized traffic checked against a
// queue-based in-order reorder-buffer model.
`default_nettype none

module tb_rob_multiport;

  localparam int BITS     = 4;
  localparam int WB_PORTS = 2;
  localparam int DEPTH    = 16;

  logic                     clk_in = 1'b0;
  logic                     rst_in, rdy_in;
  logic                     issue_valid, issue_pred_taken;
  logic [31:0]              issue_pc, issue_alt_pc;
  logic [1:0]               issue_type;
  logic [4:0]               issue_rd;
  logic                     issue_ready;
  logic [BITS-1:0]          issue_id;
  logic [WB_PORTS-1:0]      wb_valid, wb_taken;
  logic [WB_PORTS*BITS-1:0] wb_id;
  logic [WB_PORTS*32-1:0]   wb_value;
  logic [BITS-1:0]          qry_id_1, qry_id_2;
  logic                     qry_ready_1, qry_ready_2;
  logic [31:0]              qry_value_1, qry_value_2;
  logic                     commit_valid;
  logic [BITS-1:0]          commit_id;
  logic [1:0]               commit_type;
  logic [4:0]               commit_rd;
  logic [31:0]              commit_value;
  logic                     flush_out;
  logic [31:0]              flush_pc;
  logic [BITS:0]            count;
  logic                     full, empty;

  rob_multiport #(.BITS(BITS), .WB_PORTS(WB_PORTS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_ready(issue_ready), .issue_id(issue_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_taken(wb_taken),
    .qry_id_1(qry_id_1), .qry_id_2(qry_id_2),
    .qry_ready_1(qry_ready_1), .qry_ready_2(qry_ready_2),
    .qry_value_1(qry_value_1), .qry_value_2(qry_value_2),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_type(commit_type),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .flush_out(flush_out), .flush_pc(flush_pc),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alt;
    logic        pred;
    logic        done;
    logic        taken;
    logic [31:0] value;
  } ent_t;

  ent_t rob[$];
  int   next_id;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find(input logic [3:0] id);
    for (int i = 0; i < rob.size(); i++) if (rob[i].id == id) return i;
    return -1;
  endfunction

  function automatic int nth_undone(input int n);
    int seen = 0;
    for (int i = 0; i < rob.size(); i++) begin
      if (!rob[i].done) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  task automatic set_idle();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_pc = '0; issue_type = '0; issue_rd = '0;
    issue_pred_taken = 1'b0; issue_alt_pc = '0;
    wb_valid = '0; wb_id = '0; wb_value = '0; wb_taken = '0;
    qry_id_1 = '0; qry_id_2 = '0;
  endtask

  task automatic set_issue(input logic [1:0] t, input logic [31:0] pc, input logic [4:0] rd,
                           input logic pred, input logic [31:0] alt);
    issue_valid = 1'b1; issue_type = t; issue_pc = pc; issue_rd = rd;
    issue_pred_taken = pred; issue_alt_pc = alt;
  endtask

  task automatic set_wb(input int k, input logic [3:0] id, input logic [31:0] v, input logic tk);
    wb_valid[k] = 1'b1; wb_id[k*BITS +: BITS] = id; wb_value[k*32 +: 32] = v; wb_taken[k] = tk;
  endtask

  task automatic exp_query(input logic [3:0] id, output logic rdy, output logic [31:0] val);
    int i;
    rdy = 1'b0; val = '0;
    i = find(id);
    if (i >= 0 && rob[i].done) begin rdy = 1'b1; val = rob[i].value; end
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && wb_id[k*BITS +: BITS] == id) begin rdy = 1'b1; val = wb_value[k*32 +: 32]; end
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic ec, ef, qr;
    logic [31:0] efpc, ev, qv;
    logic [4:0] erd;
    sz = rob.size();
    check("count", 32'(count), 32'(sz));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("empty", 32'(empty), 32'(sz == 0));
    ec = 1'b0; ef = 1'b0; efpc = '0; ev = '0; erd = '0;
    if (rdy_in && sz > 0) ec = rob[0].done;
    if (ec) begin
      case (rob[0].typ)
        2'd0: begin erd = rob[0].rd; ev = rob[0].value; end
        2'd1: ev = rob[0].value;
        2'd2: if (rob[0].taken != rob[0].pred) begin ef = 1'b1; efpc = rob[0].alt; end
        default: begin erd = rob[0].rd; ev = rob[0].pc + 32'd4; ef = 1'b1; efpc = rob[0].value; end
      endcase
    end
    check("commit_valid", 32'(commit_valid), 32'(ec));
    check("flush_out", 32'(flush_out), 32'(ef));
    if (ef) check("flush_pc", flush_pc, efpc);
    if (ec) begin
      check("commit_id", 32'(commit_id), 32'(rob[0].id));
      check("commit_type", 32'(commit_type), 32'(rob[0].typ));
      check("commit_rd", 32'(commit_rd), 32'(erd));
      check("commit_value", commit_value, ev);
    end
    check("issue_ready", 32'(issue_ready), 32'(sz < DEPTH && !ef));
    check("issue_id", 32'(issue_id), 32'(next_id));
    exp_query(qry_id_1, qr, qv);
    check("qry_ready_1", 32'(qry_ready_1), 32'(qr));
    if (qr) check("qry_value_1", qry_value_1, qv);
    exp_query(qry_id_2, qr, qv);
    check("qry_ready_2", 32'(qry_ready_2), 32'(qr));
    if (qr) check("qry_value_2", qry_value_2, qv);
  endtask

  task automatic model_step();
    int  idx[WB_PORTS];
    bit  acc[WB_PORTS];
    bit  cm, fl, iss;
    ent_t e;
    if (!rdy_in) return;
    cm = rob.size() > 0 && rob[0].done;
    fl = cm && (rob[0].typ == 2'd3 || (rob[0].typ == 2'd2 && rob[0].taken != rob[0].pred));
    if (fl) begin
      rob.delete();
      next_id = 0;
      return;
    end
    for (int k = 0; k < WB_PORTS; k++) begin
      idx[k] = find(wb_id[k*BITS +: BITS]);
      acc[k] = wb_valid[k] && idx[k] >= 0 && !rob[idx[k]].done;
    end
    for (int k = 0; k < WB_PORTS; k++) begin
      if (acc[k]) begin
        rob[idx[k]].done  = 1'b1;
        rob[idx[k]].value = wb_value[k*32 +: 32];
        rob[idx[k]].taken = wb_taken[k];
      end
    end
    iss = issue_valid && rob.size() < DEPTH;
    if (cm) void'(rob.pop_front());
    if (iss) begin
      e.id = 4'(next_id); e.typ = issue_type; e.rd = issue_rd; e.pc = issue_pc;
      e.alt = issue_alt_pc; e.pred = issue_pred_taken; e.done = 1'b0; e.taken = 1'b0; e.value = '0;
      rob.push_back(e);
      next_id = (next_id + 1) % DEPTH;
    end
  endtask

  // Called in the low clock phase; returns at the next falling edge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    set_idle();
    rst_in = 1'b0;
    #2;
    rob.delete();
    next_id = 0;
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_issue_id", 32'(issue_id), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_flush_out", 32'(flush_out), 32'd0);
    check("rst_flush_pc", flush_pc, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic random_stim(input int wb_pct);
    int r;
    set_idle();
    rdy_in = ($urandom_range(0, 9) != 0);
    if ($urandom_range(0, 99) < 60) begin
      r = $urandom_range(0, 9);
      set_issue(r < 5 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3,
                {$urandom_range(0, 32'hFFFF), 2'b00}, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), $urandom());
    end
    for (int k = 0; k < WB_PORTS; k++) begin
      if ($urandom_range(0, 99) < wb_pct) begin
        if (rob.size() > 0 && $urandom_range(0, 4) != 0)
          set_wb(k, rob[$urandom_range(0, rob.size() - 1)].id, $urandom(), 1'($urandom_range(0, 1)));
        else
          set_wb(k, 4'($urandom_range(0, 15)), $urandom(), 1'($urandom_range(0, 1)));
      end
    end
    qry_id_1 = (wb_valid[0] && $urandom_range(0, 1) == 1) ? wb_id[0 +: BITS] : 4'($urandom_range(0, 15));
    qry_id_2 = (rob.size() > 0) ? rob[$urandom_range(0, rob.size() - 1)].id : 4'($urandom_range(0, 15));
  endtask

  initial begin
    int accepted, guard, i0, i1;
    set_idle();
    rst_in = 1'b0;
    next_id = 0;
    @(negedge clk_in);
    do_reset();

    // Fill to capacity with no writeback; the 17th issue is dropped and tail wraps to 0.
    for (int i = 0; i < DEPTH; i++) begin
      set_idle(); set_issue(2'd0, 32'h100 + 32'(i * 4), 5'(i + 1), 1'b0, '0); cycle();
    end
    set_idle(); set_issue(2'd0, 32'h500, 5'd3, 1'b0, '0);
    #1;
    check("fill_full", 32'(full), 32'd1);
    check("fill_issue_ready", 32'(issue_ready), 32'd0);
    cycle();
    #1;
    check("fill_tail_wrap", 32'(issue_id), 32'd0);
    check("fill_count", 32'(count), 32'd16);

    // Full with a done head: commit happens, concurrent issue still rejected.
    set_idle(); set_wb(0, 4'd0, 32'h1234, 1'b0); cycle();
    set_idle(); set_issue(2'd0, 32'h600, 5'd4, 1'b0, '0);
    #1;
    check("fullc_commit", 32'(commit_valid), 32'd1);
    check("fullc_issue_ready", 32'(issue_ready), 32'd0);
    cycle();
    #1;
    check("fullc_count", 32'(count), 32'd15);

    // Sustained traffic wrapping head/tail several times.
    accepted = 0; guard = 0;
    while (accepted < 40 && guard < 400) begin
      set_idle();
      set_issue(2'(($urandom_range(0, 1))), 32'h700 + 32'(guard * 4), 5'd5, 1'b0, '0);
      i0 = nth_undone(0); i1 = nth_undone(1);
      if (i0 >= 0) set_wb(0, rob[i0].id, $urandom(), 1'b0);
      if (i1 >= 0) set_wb(1, rob[i1].id, $urandom(), 1'b0);
      if (rob.size() < DEPTH) accepted++;
      cycle();
      guard++;
    end
    check("wrap_issues", 32'(accepted), 32'd40);

    // Reset with entries in flight.
    do_reset();

    // Out-of-order writeback, in-order commit.
    set_idle(); set_issue(2'd0, 32'h10, 5'd1, 1'b0, '0); cycle();
    set_idle(); set_issue(2'd0, 32'h14, 5'd2, 1'b0, '0); cycle();
    set_idle(); set_wb(0, 4'd1, 32'h55, 1'b0); set_wb(1, 4'd0, 32'hAA, 1'b0); cycle();
    set_idle();
    #1;
    check("ooo_c0_valid", 32'(commit_valid), 32'd1);
    check("ooo_c0_id", 32'(commit_id), 32'd0);
    check("ooo_c0_value", commit_value, 32'hAA);
    cycle();
    #1;
    check("ooo_c1_id", 32'(commit_id), 32'd1);
    check("ooo_c1_value", commit_value, 32'h55);
    cycle();

    // Same-id writeback on both ports, with query bypass in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle(); set_issue(2'd0, 32'h20 + 32'(i * 4), 5'd7, 1'b0, '0); cycle();
    end
    set_idle(); set_wb(0, 4'd3, 32'h11, 1'b0); set_wb(1, 4'd3, 32'h22, 1'b0); qry_id_1 = 4'd3;
    #1;
    check("dup_byp_ready", 32'(qry_ready_1), 32'd1);
    check("dup_byp_value", qry_value_1, 32'h22);
    cycle();
    set_idle(); qry_id_1 = 4'd3;
    #1;
    check("dup_stored_ready", 32'(qry_ready_1), 32'd1);
    check("dup_stored_value", qry_value_1, 32'h22);
    cycle();

    // Mispredicted branch with two younger entries.
    do_reset();
    set_idle(); set_issue(2'd2, 32'h100, 5'd9, 1'b1, 32'h1000); cycle();
    set_idle(); set_issue(2'd0, 32'h104, 5'd2, 1'b0, '0); cycle();
    set_idle(); set_issue(2'd0, 32'h108, 5'd3, 1'b0, '0); cycle();
    set_idle(); set_wb(0, 4'd0, 32'h0, 1'b0); cycle();
    set_idle();
    #1;
    check("br_flush", 32'(flush_out), 32'd1);
    check("br_flush_pc", flush_pc, 32'h1000);
    check("br_commit_rd", 32'(commit_rd), 32'd0);
    cycle();
    #1;
    check("br_flush_after", 32'(flush_out), 32'd0);
    check("br_count", 32'(count), 32'd0);
    check("br_empty", 32'(empty), 32'd1);

    // Jalr always redirects to the written-back target.
    set_idle(); set_issue(2'd3, 32'h200, 5'd1, 1'b0, '0); cycle();
    set_idle(); set_wb(1, 4'd0, 32'h300, 1'b0); cycle();
    set_idle();
    #1;
    check("jalr_rd", 32'(commit_rd), 32'd1);
    check("jalr_value", commit_value, 32'h204);
    check("jalr_flush_pc", flush_pc, 32'h300);
    cycle();

    // Randomized traffic, varying writeback pressure so full and empty both occur.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      random_stim((n / 150) % 2 == 0 ? 60 : 15);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
